mcd_mem_arbiter: RTL

- Parametrised successor to the fixed master/slave memory mappers: multiplexes NCLI MegaCD-side memory clients (prg, wrm0, wrm1, pcm, bram, ...) onto one 16-bit system memory bank (rom0/rom1/sram/bram MemCtrl bus).
- Each client owns a region selected by its index in the upper address bits.
- Arbitration is round-robin or fixed-priority, set by a parameter.
- Accesses are multi-cycle, with a req/ack handshake per client.

---
 rtl/mcd_pkg.sv | 17 +
 rtl/mcd_rr_pick.sv | 38 +++
 rtl/mcd_mem_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mcd_pkg.sv
// Shared types and constants for the MegaCD memory arbiter and its winner picker.
package mcd_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } arb_state_t;

   localparam int MODE_RR  = 0;
   localparam int MODE_FIX = 1;
   localparam int CNT_W    = 4;

   // Region-index width; a single bit still exists for the two-client case.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/mcd_rr_pick.sv
// Combinational winner select: round-robin from last grant, or lowest index first.
module mcd_rr_pick
   import mcd_pkg::*;
#(
   parameter int NCLI = 4,
   parameter int IW   = idx_w(NCLI),
   parameter int MODE = MODE_RR
) (
   input  logic [NCLI-1:0] i_req,
   input  logic [IW-1:0]   i_last,
   output logic [IW-1:0]   o_idx,
   output logic            o_vld
);
   logic [IW-1:0] w_cand;

   // Scan from the lowest-priority candidate up so the last hit is the winner.
   always_comb begin
      o_idx  = '0;
      o_vld  = 1'b0;
      w_cand = '0;
      if (MODE == MODE_FIX) begin
         for (int i = NCLI - 1; i >= 0; i--) begin
            if (i_req[i]) begin
               o_idx = IW'(i);
               o_vld = 1'b1;
            end
         end
      end else begin
         for (int k = NCLI; k >= 1; k--) begin
            w_cand = IW'((int'(i_last) + k) % NCLI);
            if (i_req[w_cand]) begin
               o_idx = w_cand;
               o_vld = 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/mcd_mem_arbiter.sv
// Multiplexes NCLI MegaCD memory clients onto one 16-bit bank with a
// per-client req/ack handshake and a fixed-length strobe window.
module mcd_mem_arbiter
   import mcd_pkg::*;
#(
   parameter int NCLI    = 4,
   parameter int AW      = 17,
   parameter int ACC_CYC = 3,
   parameter int MODE    = MODE_RR,
   localparam int IW     = idx_w(NCLI)
) (
   input  logic                 i_clk,
   input  logic                 i_map_rst,
   input  logic [NCLI-1:0]      i_cli_req,
   input  logic [NCLI-1:0]      i_cli_we,
   input  logic [2*NCLI-1:0]    i_cli_be,
   input  logic [NCLI*AW-1:0]   i_cli_addr,
   input  logic [NCLI*16-1:0]   i_cli_dati,
   output logic [NCLI-1:0]      o_cli_ack,
   output logic [15:0]          o_cli_dato,
   output logic [AW+IW-1:0]     o_mem_addr,
   output logic [15:0]          o_mem_dati,
   input  logic [15:0]          i_mem_do,
   output logic                 o_mem_oe,
   output logic                 o_mem_we_lo,
   output logic                 o_mem_we_hi,
   output logic                 o_busy
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACC_CYC - 1);

   logic [1:0]    w_be   [NCLI];
   logic [AW-1:0] w_addr [NCLI];
   logic [15:0]   w_dati [NCLI];

   for (genvar g = 0; g < NCLI; g++) begin : g_cli
      assign w_be[g]   = i_cli_be[2*g +: 2];
      assign w_addr[g] = i_cli_addr[AW*g +: AW];
      assign w_dati[g] = i_cli_dati[16*g +: 16];
   end

   arb_state_t       r_state, w_state_nxt;
   logic [IW-1:0]    r_idx, r_last, w_pick_idx;
   logic             w_pick_vld, w_grant, w_acc_end;
   logic             r_we;
   logic [AW-1:0]    r_addr;
   logic [15:0]      r_dati, r_dato;
   logic [CNT_W-1:0] r_cnt;
   logic             r_oe, r_we_lo, r_we_hi;
   logic [NCLI-1:0]  r_ack;

   mcd_rr_pick #(
      .NCLI (NCLI),
      .IW   (IW),
      .MODE (MODE)
   ) u_pick (
      .i_req  (i_cli_req),
      .i_last (r_last),
      .o_idx  (w_pick_idx),
      .o_vld  (w_pick_vld)
   );

   always_ff @(posedge i_clk) begin
      if (i_map_rst) r_state <= ST_IDLE;
      else           r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_acc_end   = 1'b0;
      unique case (r_state)
         ST_IDLE: begin
            if (w_pick_vld) begin
               w_grant     = 1'b1;
               w_state_nxt = ST_ACC;
            end
         end
         ST_ACC: begin
            if (r_cnt == '0) begin
               w_acc_end   = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Strobes are computed at grant so they are already registered in the first ACC cycle.
   always_ff @(posedge i_clk) begin
      if (i_map_rst) begin
         r_idx   <= '0;
         r_last  <= IW'(NCLI - 1);
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_dati  <= '0;
         r_dato  <= '0;
         r_cnt   <= '0;
         r_oe    <= 1'b0;
         r_we_lo <= 1'b0;
         r_we_hi <= 1'b0;
         r_ack   <= '0;
      end else begin
         r_ack <= '0;
         if (w_grant) begin
            r_idx   <= w_pick_idx;
            r_we    <= i_cli_we[w_pick_idx];
            r_addr  <= w_addr[w_pick_idx];
            r_dati  <= w_dati[w_pick_idx];
            r_cnt   <= CNT_LOAD;
            r_oe    <= ~i_cli_we[w_pick_idx];
            r_we_lo <= i_cli_we[w_pick_idx] & w_be[w_pick_idx][0];
            r_we_hi <= i_cli_we[w_pick_idx] & w_be[w_pick_idx][1];
         end else if (r_state == ST_ACC) begin
            if (w_acc_end) begin
               r_oe         <= 1'b0;
               r_we_lo      <= 1'b0;
               r_we_hi      <= 1'b0;
               r_ack[r_idx] <= 1'b1;
               if (!r_we) r_dato <= i_mem_do;
            end else begin
               r_cnt <= r_cnt - CNT_W'(1);
            end
         end else if (r_state == ST_DONE) begin
            r_last <= r_idx;
         end
      end
   end

   assign o_cli_ack   = r_ack;
   assign o_cli_dato  = r_dato;
   assign o_mem_addr  = {r_idx, r_addr};
   assign o_mem_dati  = r_dati;
   assign o_mem_oe    = r_oe;
   assign o_mem_we_lo = r_we_lo;
   assign o_mem_we_hi = r_we_hi;
   assign o_busy      = (r_state != ST_IDLE);
endmodule
